manchester_tx_ctrl: RTL and testbench

MANCHESTER_TX_CTRL -- requirements
Module: manchester_tx_ctrl

---
 rtl/manchester_pkg.sv | 18 +
 rtl/manchester_tx_ctrl_bit_timer.sv | 39 +++
 rtl/manchester_tx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_manchester_tx_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester transmit controller.
//   tx_state_t  : controller FSM states
//   SFD_DEFAULT : default start-frame delimiter byte
//   BYTE_BITS   : bits per SFD / payload byte
package manchester_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD_TX,
    S_DATA,
    S_GAP
  } tx_state_t;

  localparam logic [7:0] SFD_DEFAULT = 8'hD5;
  localparam int         BYTE_BITS   = 8;

endpackage

// File: rtl/manchester_tx_ctrl_bit_timer.sv
// Half-bit timebase for the Manchester transmitter.
//   clk, rst     : clock, asynchronous active-high reset
//   clr_i        : hold the timer at the start of a bit (used while idle)
//   half_tick_o  : strobe on the last cycle of every half-bit
//   bit_end_o    : strobe on the last cycle of every full bit
module manchester_bit_timer #(
  parameter int CLKS_PER_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic half_tick_o,
  output logic bit_end_o
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_HALF - 1);

  logic [7:0] cnt_q;
  logic       phase_q;  // 0 = first half of the bit, 1 = second half

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 8'd1;
    end
  end

  assign half_tick_o = !clr_i && (cnt_q == LAST);
  assign bit_end_o   = half_tick_o && phase_q;

endmodule

// File: rtl/manchester_tx_ctrl.sv
// Manchester frame transmitter: preamble, SFD, then len payload bytes
// (LSB first) fed through a one-byte holding buffer, then an idle gap.
//   clk, rst          : clock, asynchronous active-high reset
//   start, len        : frame request and payload byte count (IDLE only)
//   tx_data, tx_valid : payload byte stream
//   tx_ready          : a payload byte is accepted this cycle if tx_valid
//   line_out, line_en : encoded line level and driver enable
//   busy              : controller not idle
//   done, underrun    : one-cycle completion / abort-for-lack-of-data pulses
module manchester_tx_ctrl
  import manchester_pkg::*;
#(
  parameter int         CLKS_PER_HALF = 4,
  parameter int         PREAMBLE_BITS = 16,
  parameter int         GAP_BITS      = 2,
  parameter logic [7:0] SFD           = SFD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       line_out,
  output logic       line_en,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [6:0] PRE_LAST  = 7'(PREAMBLE_BITS - 1);
  localparam logic [6:0] BYTE_LAST = 7'(BYTE_BITS - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_BITS - 1);

  tx_state_t  state_q;
  logic [7:0] len_q;
  logic [7:0] acc_cnt_q;   // payload bytes accepted into the buffer
  logic [7:0] sent_cnt_q;  // payload bytes moved into the shift register
  logic [7:0] buf_q;
  logic       buf_full_q;
  logic [7:0] sh_q;
  logic [6:0] bit_cnt_q;   // bit index within preamble or current byte
  logic [3:0] gap_cnt_q;
  logic       half_q;      // second half of the current bit
  logic       done_q;
  logic       underrun_q;

  logic half_tick, bit_end;
  logic active, accept, cur_bit;

  manchester_bit_timer #(
    .CLKS_PER_HALF(CLKS_PER_HALF)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == S_IDLE),
    .half_tick_o(half_tick),
    .bit_end_o  (bit_end)
  );

  assign active   = (state_q == S_PREAMBLE) || (state_q == S_SFD_TX) ||
                    (state_q == S_DATA);
  assign tx_ready = active && !buf_full_q && (acc_cnt_q < len_q);
  assign accept   = tx_valid && tx_ready;

  // Preamble alternates 1,0,1,... so bit parity selects the level.
  assign cur_bit  = (state_q == S_PREAMBLE) ? ~bit_cnt_q[0] : sh_q[0];

  // First half carries the bit value, second half its complement.
  assign line_en  = active;
  assign line_out = active && (cur_bit ^ half_q);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign underrun = underrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      acc_cnt_q  <= '0;
      sent_cnt_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      half_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;

      if (state_q == S_IDLE)  half_q <= 1'b0;
      else if (half_tick)     half_q <= ~half_q;

      // Accept needs an empty buffer and a load needs a full one, so the
      // buffer update below never collides with a byte-boundary load.
      if (accept) begin
        buf_q      <= tx_data;
        buf_full_q <= 1'b1;
        acc_cnt_q  <= acc_cnt_q + 8'd1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (start && (len != 8'd0)) begin
            state_q    <= S_PREAMBLE;
            len_q      <= len;
            acc_cnt_q  <= '0;
            sent_cnt_q <= '0;
            buf_full_q <= 1'b0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
          end
        end

        S_PREAMBLE: begin
          if (bit_end) begin
            if (bit_cnt_q == PRE_LAST) begin
              state_q   <= S_SFD_TX;
              bit_cnt_q <= '0;
              sh_q      <= SFD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 7'd1;
            end
          end
        end

        S_SFD_TX, S_DATA: begin
          if (bit_end) begin
            if (bit_cnt_q != BYTE_LAST) begin
              bit_cnt_q <= bit_cnt_q + 7'd1;
              sh_q      <= sh_q >> 1;
            end else if ((state_q == S_DATA) && (sent_cnt_q == len_q)) begin
              state_q   <= S_GAP;
              gap_cnt_q <= '0;
            end else if (buf_full_q) begin
              state_q    <= S_DATA;
              sh_q       <= buf_q;
              buf_full_q <= 1'b0;
              sent_cnt_q <= sent_cnt_q + 8'd1;
              bit_cnt_q  <= '0;
            end else begin
              // Nothing to send at the boundary: abort the frame.
              underrun_q <= 1'b1;
              state_q    <= S_GAP;
              gap_cnt_q  <= '0;
            end
          end
        end

        S_GAP: begin
          if (bit_end) begin
            if (gap_cnt_q == GAP_LAST) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else begin
              gap_cnt_q <= gap_cnt_q + 4'd1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_tx_ctrl.sv
// Self-checking bench for manchester_tx_ctrl (CLKS_PER_HALF=2).
module tb_manchester_tx_ctrl;

  localparam int C   = 2;
  localparam int PRE = 16;
  localparam int GB  = 2;
  localparam int LIMIT = 20000;

  logic       clk = 1'b0;
  logic       rst, start, tx_valid;
  logic [7:0] len, tx_data;
  logic       tx_ready, line_out, line_en, busy, done, underrun;

  always #5 clk = ~clk;

  manchester_tx_ctrl #(
    .CLKS_PER_HALF(C),
    .PREAMBLE_BITS(PRE),
    .GAP_BITS     (GB),
    .SFD          (8'hD5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .line_out(line_out),
    .line_en (line_en),
    .busy    (busy),
    .done    (done),
    .underrun(underrun)
  );

  int checks = 0, failures = 0;

  // Reference model: mode 0 idle, 1 on the line, 2 gap. Expected line level
  // comes from a queue of bits to send indexed by elapsed cycles.
  int         m_mode, m_t, m_len, m_acc, m_sent, m_gap_t;
  bit         m_buf_full, m_done_p, m_und_p;
  logic [7:0] m_buf;
  bit         m_bits[$];
  logic [7:0] sfd_v = 8'hD5;

  // Per-frame observations.
  int dut_acc, n_und, n_done, n_busy, ready_after;
  bit last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_mode = 0; m_t = 0; m_len = 0; m_acc = 0; m_sent = 0; m_gap_t = 0;
    m_buf_full = 0; m_done_p = 0; m_und_p = 0; m_buf = '0;
    m_bits.delete();
  endfunction

  // {busy, line_en, line_out, tx_ready, done, underrun}
  function automatic logic [5:0] m_out();
    bit b, lvl, en, rdy;
    en = (m_mode == 1);
    lvl = 1'b0;
    if (en) begin
      b   = m_bits[m_t / (2*C)];
      lvl = ((m_t % (2*C)) < C) ? b : !b;
    end
    rdy = en && !m_buf_full && (m_acc < m_len);
    return {m_mode != 0, en, lvl, rdy, m_done_p, m_und_p};
  endfunction

  function automatic void m_adv();
    bit nd, nu, rdy;
    int b;
    nd = 0; nu = 0;
    if (rst) begin m_reset(); return; end
    case (m_mode)
      0: if (start && len != 8'd0) begin
        m_mode = 1; m_t = 0; m_len = len; m_acc = 0; m_sent = 0; m_buf_full = 0;
        m_bits.delete();
        for (int i = 0; i < PRE; i++) m_bits.push_back(i % 2 == 0);
        for (int i = 0; i < 8; i++)   m_bits.push_back(sfd_v[i]);
      end
      1: begin
        rdy = !m_buf_full && (m_acc < m_len);
        if (m_t % (2*C) == 2*C - 1) begin
          b = m_t / (2*C);
          if (b >= PRE + 7 && (b - PRE) % 8 == 7) begin
            if (m_sent == m_len) begin
              m_mode = 2; m_gap_t = 0;
            end else if (m_buf_full) begin
              for (int i = 0; i < 8; i++) m_bits.push_back(m_buf[i]);
              m_buf_full = 0; m_sent++;
            end else begin
              nu = 1; m_mode = 2; m_gap_t = 0;
            end
          end
        end
        if (tx_valid && rdy) begin m_buf = tx_data; m_buf_full = 1; m_acc++; end
        m_t++;
      end
      default: begin
        m_gap_t++;
        if (m_gap_t == GB*2*C) begin m_mode = 0; nd = 1; end
      end
    endcase
    m_done_p = nd; m_und_p = nu;
  endfunction

  // One clock: compare at negedge, advance model, return at posedge+1.
  task automatic step();
    @(negedge clk);
    chk("outputs", {26'd0, busy, line_en, line_out, tx_ready, done, underrun}, {26'd0, m_out()});
    if (dut_acc >= 255 && tx_ready) ready_after++;
    last_acc = tx_valid && tx_ready;
    if (last_acc) dut_acc++;
    if (underrun) n_und++;
    if (done)     n_done++;
    if (busy)     n_busy++;
    m_adv();
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 always valid, 1 valid until first byte taken, 2 random.
  // abort_at >= 0 returns early once the frame reaches that cycle offset.
  task automatic run_frame(input int l, input logic [7:0] d0, input int vmode,
                           input bit mid, input int abort_at);
    int  cyc;
    bit  got;
    cyc = 0; got = 0;
    dut_acc = 0; n_und = 0; n_done = 0; n_busy = 0; ready_after = 0;
    len = l[7:0]; start = 1'b1; tx_data = d0;
    tx_valid = (vmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    step();
    start = 1'b0;
    while (m_mode != 0 && cyc < LIMIT) begin
      if (last_acc) begin got = 1; tx_data = 8'($urandom); end
      case (vmode)
        0:       tx_valid = 1'b1;
        1:       tx_valid = !got;
        default: tx_valid = ($urandom_range(0, 3) != 0);
      endcase
      // Stray start (with a different len) in the middle of DATA.
      start = mid && m_mode == 1 && m_t == (PRE + 10) * 2 * C;
      len   = start ? 8'd1 : l[7:0];
      step();
      cyc++;
      if (abort_at >= 0 && m_mode == 1 && m_t == abort_at) return;
    end
    start = 1'b0; len = l[7:0]; tx_valid = 1'b0;
    if (cyc >= LIMIT) begin
      checks++; failures++;
      $display("FAIL frame_timeout: still busy after %0d cycles, required idle", cyc);
    end
    repeat (3) step();
  endtask

  typedef struct {
    int         l;
    logic [7:0] d0;
    int         vmode;
    bit         mid;
    int         exp_acc;
    int         exp_und;
    int         exp_done;
    int         exp_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // busy cycles = (PRE + 8 + 8*bytes_on_line)*2C + GB*2C
    vecs[0] = '{1,   8'hA5, 0, 1'b0, 1,   0, 1, 136};
    vecs[1] = '{3,   8'h3C, 1, 1'b0, 1,   1, 1, 136};
    vecs[2] = '{0,   8'h00, 0, 1'b0, 0,   0, 0, 0};
    vecs[3] = '{4,   8'h96, 0, 1'b1, 4,   0, 1, 232};
    vecs[4] = '{255, 8'h01, 0, 1'b0, 255, 0, 1, 8264};

    rst = 1'b1; start = 1'b0; len = '0; tx_data = '0; tx_valid = 1'b0;
    m_reset();
    #1;
    chk("reset_state", {26'd0, busy, line_en, line_out, tx_ready, done, underrun}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_frame(vecs[i].l, vecs[i].d0, vecs[i].vmode, vecs[i].mid, -1);
      chk($sformatf("v%0d_accepted", i), dut_acc, vecs[i].exp_acc);
      chk($sformatf("v%0d_underrun", i), n_und, vecs[i].exp_und);
      chk($sformatf("v%0d_done", i), n_done, vecs[i].exp_done);
      chk($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_ready_after_255", i), ready_after, 0);
    end

    // Reset in the middle of SFD_TX: everything drops without a clock edge.
    run_frame(2, 8'h5A, 0, 1'b0, PRE * 2 * C + 6);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_sfd_async", {26'd0, busy, line_en, line_out, tx_ready, done, underrun}, 32'd0);
    m_reset();
    n_done = 0; n_und = 0;
    repeat (3) step();
    chk("rst_no_done", n_done, 0);
    chk("rst_no_underrun", n_und, 0);
    rst = 1'b0;
    step();
    run_frame(2, 8'hC3, 0, 1'b0, -1);
    chk("after_rst_accepted", dut_acc, 2);
    chk("after_rst_done", n_done, 1);
    chk("after_rst_underrun", n_und, 0);

    // Randomized frames against the model.
    for (int k = 0; k < 8; k++)
      run_frame($urandom_range(1, 5), 8'($urandom), 2, 1'($urandom_range(0, 1)), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
